// File: rtl/aes_pkg.sv
// Shared types and default widths for the AES entropy responder.
// The ERROR state exists only when AES_ENTROPY_RESP_REP_CHECK_EN is defined.
package aes_pkg;

  localparam int unsigned EntropyWidthDefault = 32;
  localparam int unsigned SrcWidthDefault     = 128;
  localparam int unsigned BufDepthDefault     = 2;

`ifdef AES_ENTROPY_RESP_REP_CHECK_EN
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    SERVE = 2'b01,
    ERROR = 2'b10
  } aes_ent_resp_e;
`else
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    SERVE = 2'b01
  } aes_ent_resp_e;
`endif

endpackage

// File: rtl/prim_fifo_sync.sv
// Synchronous FIFO without pass-through; a full FIFO refuses writes even when read in the same cycle.
module prim_fifo_sync #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             wvalid_i,
  output logic             wready_o,
  input  logic [Width-1:0] wdata_i,
  output logic             rvalid_o,
  input  logic             rready_i,
  output logic [Width-1:0] rdata_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             wr_en, rd_en;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign wready_o = (cnt_q != CntW'(Depth));
  assign rvalid_o = (cnt_q != '0);
  assign rdata_o  = mem_q[rptr_q];
  assign wr_en    = wvalid_i & wready_o & ~clr_i;
  assign rd_en    = rready_i & rvalid_o & ~clr_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (clr_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_en) wptr_q <= ptr_inc(wptr_q);
      if (rd_en) rptr_q <= ptr_inc(rptr_q);
      case ({wr_en, rd_en})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage carries no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/aes_entropy_responder.sv
// Buffers wide upstream entropy words and serves them LSB-chunk-first, one chunk per acked cycle.
// Optional repetition check enabled by defining AES_ENTROPY_RESP_REP_CHECK_EN.
module aes_entropy_responder
  import aes_pkg::*;
#(
  parameter int unsigned EntropyWidth = EntropyWidthDefault,
  parameter int unsigned SrcWidth     = SrcWidthDefault,
  parameter int unsigned BufDepth     = BufDepthDefault
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    flush_i,
  input  logic                    src_valid_i,
  output logic                    src_ready_o,
  input  logic [SrcWidth-1:0]     src_data_i,
  input  logic                    entropy_req_i,
  output logic                    entropy_ack_o,
  output logic [EntropyWidth-1:0] entropy_o,
  output logic                    rep_err_o
);

  localparam int unsigned NumChunks = SrcWidth / EntropyWidth;
  localparam int unsigned CntWidth  = (NumChunks > 1) ? $clog2(NumChunks) : 1;

  if (SrcWidth % EntropyWidth != 0) begin : g_width_chk
    $error("SrcWidth must be a multiple of EntropyWidth");
  end
  if (BufDepth < 1) begin : g_depth_chk
    $error("BufDepth must be at least 1");
  end

  aes_ent_resp_e         state_q, state_d;
  logic [SrcWidth-1:0]   shift_q;
  logic [CntWidth-1:0]   cnt_q;
  logic                  shift_valid_q;
  logic                  err_q;
  logic                  rep_match;
  logic                  ack, last_chunk, load;
  logic                  fifo_wready, fifo_rvalid;
  logic [SrcWidth-1:0]   fifo_rdata;

  prim_fifo_sync #(
    .Width (SrcWidth),
    .Depth (BufDepth)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (flush_i),
    .wvalid_i (src_valid_i & ~flush_i & ~err_q),
    .wready_o (fifo_wready),
    .wdata_i  (src_data_i),
    .rvalid_o (fifo_rvalid),
    .rready_i (load),
    .rdata_o  (fifo_rdata)
  );

  // The shift register holds a word in every state except EMPTY.
  assign shift_valid_q = (state_q != EMPTY);

  assign ack        = entropy_req_i & shift_valid_q & ~rep_match & ~err_q & ~flush_i;
  assign last_chunk = (cnt_q == CntWidth'(NumChunks - 1));
  assign load       = ~flush_i & ~err_q & fifo_rvalid & (~shift_valid_q | (ack & last_chunk));

  assign src_ready_o   = fifo_wready & ~flush_i & ~err_q;
  assign entropy_ack_o = ack;
  assign entropy_o     = shift_q[EntropyWidth-1:0];

`ifdef AES_ENTROPY_RESP_REP_CHECK_EN
  logic [EntropyWidth-1:0] prev_q;
  logic                    prev_valid_q;

  assign err_q     = (state_q == ERROR);
  assign rep_err_o = err_q;
  assign rep_match = entropy_req_i & shift_valid_q & ~err_q & prev_valid_q &
                     (shift_q[EntropyWidth-1:0] == prev_q);

  // Last delivered chunk; forgotten on flush so the next chunk is never compared.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
    end else if (flush_i) begin
      prev_valid_q <= 1'b0;
    end else if (ack) begin
      prev_q       <= shift_q[EntropyWidth-1:0];
      prev_valid_q <= 1'b1;
    end
  end
`else
  assign err_q     = 1'b0;
  assign rep_err_o = 1'b0;
  assign rep_match = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= EMPTY;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (load) state_d = SERVE;
        SERVE: begin
`ifdef AES_ENTROPY_RESP_REP_CHECK_EN
          if (rep_match) state_d = ERROR;
          else
`endif
          if (ack && last_chunk && !load) state_d = EMPTY;
        end
`ifdef AES_ENTROPY_RESP_REP_CHECK_EN
        ERROR: state_d = ERROR;
`endif
        default: state_d = EMPTY;
      endcase
    end
  end

  // Down-sizing datapath: load a fresh word or shift out the acked chunk.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (flush_i) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (load) begin
      shift_q <= fifo_rdata;
      cnt_q   <= '0;
    end else if (ack) begin
      shift_q <= shift_q >> EntropyWidth;
      cnt_q   <= last_chunk ? '0 : cnt_q + CntWidth'(1);
    end
  end

  ack_needs_req: assert property (@(posedge clk_i) disable iff (!rst_ni)
    entropy_ack_o |-> entropy_req_i);

  data_stable_while_stalled: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (entropy_req_i & ~entropy_ack_o & shift_valid_q & ~flush_i) |=> $stable(entropy_o));

endmodule

// File: tb/tb_aes_entropy_responder.sv
// Self-checking bench for aes_entropy_responder: directed table, corner sequences and random traffic
// against a queue-based reference model.
module tb_aes_entropy_responder;

  localparam int unsigned EW = 32;
  localparam int unsigned SW = 128;
  localparam int unsigned BD = 2;
  localparam int unsigned NC = SW / EW;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          flush_i;
  logic          src_valid_i;
  logic          src_ready_o;
  logic [SW-1:0] src_data_i;
  logic          entropy_req_i;
  logic          entropy_ack_o;
  logic [EW-1:0] entropy_o;
  logic          rep_err_o;

  always #5 clk_i = ~clk_i;

  aes_entropy_responder #(
    .EntropyWidth (EW),
    .SrcWidth     (SW),
    .BufDepth     (BD)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .flush_i       (flush_i),
    .src_valid_i   (src_valid_i),
    .src_ready_o   (src_ready_o),
    .src_data_i    (src_data_i),
    .entropy_req_i (entropy_req_i),
    .entropy_ack_o (entropy_ack_o),
    .entropy_o     (entropy_o),
    .rep_err_o     (rep_err_o)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: words held by the responder (FIFO plus shift register) with acceptance cycle.
  typedef struct {
    logic [SW-1:0] data;
    int            acc;
  } word_t;

  word_t mq[$];
  int    mpos = 0;
  int    cyc  = 0;
  bit    model_on = 1'b1;

  logic          obs_ack, obs_ready, obs_err;
  logic [EW-1:0] obs_data;

  typedef struct {
    logic          req;
    logic          valid;
    logic [SW-1:0] data;
    logic          exp_ack;
    logic [EW-1:0] exp_data;
    logic          exp_ready;
  } vec_t;

  task automatic check(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    mpos = 0;
  endtask

  // One clock cycle: drive at negedge, sample shortly after, compare to model, advance model.
  task automatic step(input logic req, input logic valid, input logic flush, input logic [SW-1:0] data);
    bit            head_rdy, e_ack, e_rdy;
    int            fcnt;
    logic [SW-1:0] hw;
    logic [EW-1:0] e_data;
    word_t         w;
    @(negedge clk_i);
    entropy_req_i = req;
    src_valid_i   = valid;
    flush_i       = flush;
    src_data_i    = data;
    #1;
    obs_ack   = entropy_ack_o;
    obs_ready = src_ready_o;
    obs_err   = rep_err_o;
    obs_data  = entropy_o;
    head_rdy  = (mq.size() > 0) && (cyc >= mq[0].acc + 2);
    fcnt      = mq.size() - (head_rdy ? 1 : 0);
    e_rdy     = !flush && (fcnt < BD);
    e_ack     = req && head_rdy && !flush;
    e_data    = '0;
    if (head_rdy) begin
      hw     = mq[0].data >> (EW * mpos);
      e_data = hw[EW-1:0];
    end
    if (model_on) begin
      check("model_ack", SW'(obs_ack), SW'(e_ack));
      check("model_ready", SW'(obs_ready), SW'(e_rdy));
      check("model_rep_err", SW'(obs_err), SW'(0));
      if (e_ack) check("model_data", SW'(obs_data), SW'(e_data));
    end
    if (flush) begin
      model_clear();
    end else begin
      if (e_ack) begin
        mpos++;
        if (mpos == NC) begin
          void'(mq.pop_front());
          mpos = 0;
        end
      end
      if (valid && e_rdy) begin
        w.data = data;
        w.acc  = cyc;
        mq.push_back(w);
      end
    end
    cyc++;
  endtask

  function automatic logic [SW-1:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [EW-1:0] chunk(input logic [SW-1:0] w, input int k);
    logic [SW-1:0] t;
    t = w >> (EW * k);
    return t[EW-1:0];
  endfunction

  initial begin
    vec_t          tbl[7];
    logic [SW-1:0] w0, w1, w2, w3;
    int            acks, first_ack, last_ack, accepted;

    rst_ni = 1'b0; flush_i = 1'b0; src_valid_i = 1'b0; src_data_i = '0; entropy_req_i = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    check("reset_ack", SW'(entropy_ack_o), SW'(0));
    check("reset_data", SW'(entropy_o), SW'(0));
    check("reset_rep_err", SW'(rep_err_o), SW'(0));
    @(negedge clk_i);
    rst_ni = 1'b1;
    step(0, 0, 0, '0);
    check("reset_ready", SW'(obs_ready), SW'(1));

    // Single word, request held from cycle 0.
    w0 = 128'h44444444_33333333_22222222_11111111;
    tbl[0] = '{1'b1, 1'b1, w0, 1'b0, 32'h0, 1'b1};
    tbl[1] = '{1'b1, 1'b0, '0, 1'b0, 32'h0, 1'b1};
    tbl[2] = '{1'b1, 1'b0, '0, 1'b1, 32'h11111111, 1'b1};
    tbl[3] = '{1'b1, 1'b0, '0, 1'b1, 32'h22222222, 1'b1};
    tbl[4] = '{1'b1, 1'b0, '0, 1'b1, 32'h33333333, 1'b1};
    tbl[5] = '{1'b1, 1'b0, '0, 1'b1, 32'h44444444, 1'b1};
    tbl[6] = '{1'b1, 1'b0, '0, 1'b0, 32'h0, 1'b1};
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].req, tbl[i].valid, 1'b0, tbl[i].data);
      check($sformatf("tbl_ack[%0d]", i), SW'(obs_ack), SW'(tbl[i].exp_ack));
      check($sformatf("tbl_ready[%0d]", i), SW'(obs_ready), SW'(tbl[i].exp_ready));
      if (tbl[i].exp_ack) check($sformatf("tbl_data[%0d]", i), SW'(obs_data), SW'(tbl[i].exp_data));
    end

    // Two back-to-back words: eight consecutive acks.
    w0 = rnd_word(); w1 = rnd_word();
    step(1, 1, 0, w0);
    step(1, 1, 0, w1);
    acks = 0; first_ack = -1; last_ack = -1;
    for (int i = 0; i < 12; i++) begin
      step(1, 0, 0, '0);
      if (obs_ack) begin
        acks++;
        if (first_ack < 0) first_ack = i;
        last_ack = i;
      end
    end
    check("b2b_ack_count", SW'(acks), SW'(8));
    check("b2b_no_gap", SW'(last_ack - first_ack + 1), SW'(8));

    // Request low with valid held: capacity is BufDepth+1 words.
    w0 = rnd_word(); w1 = rnd_word(); w2 = rnd_word(); w3 = rnd_word();
    accepted = 0;
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, (i == 0) ? w0 : (i == 1) ? w1 : (i == 2) ? w2 : w3);
      if (obs_ready) accepted++;
      if (i == 3) check("cap_ready_low", SW'(obs_ready), SW'(0));
    end
    check("cap_accepted", SW'(accepted), SW'(3));
    step(1, 0, 0, '0);
    check("cap_first_ack", SW'(obs_ack), SW'(1));
    check("cap_first_data", SW'(obs_data), SW'(chunk(w0, 0)));
    repeat (14) step(1, 0, 0, '0);

    // Stall mid-word, resume, then flush.
    w0 = 128'hDDDD0004_CCCC0003_BBBB0002_AAAA0001;
    step(0, 1, 0, w0);
    step(0, 0, 0, '0);
    step(1, 0, 0, '0);
    step(1, 0, 0, '0);
    repeat (5) begin
      step(0, 0, 0, '0);
      check("stall_no_ack", SW'(obs_ack), SW'(0));
    end
    step(1, 0, 0, '0);
    check("resume_ack", SW'(obs_ack), SW'(1));
    check("resume_data", SW'(obs_data), SW'(32'hCCCC0003));
    step(1, 0, 1, '0);
    check("flush_ack", SW'(obs_ack), SW'(0));
    step(1, 0, 0, '0);
    check("post_flush_ack", SW'(obs_ack), SW'(0));
    check("post_flush_ready", SW'(obs_ready), SW'(1));
    w1 = rnd_word();
    step(1, 1, 0, w1);
    step(1, 0, 0, '0);
    step(1, 0, 0, '0);
    check("post_flush_chunk0", SW'(obs_data), SW'(chunk(w1, 0)));
    repeat (4) step(1, 0, 0, '0);

    // Repeated chunks.
    w0 = {4{32'hA5A5A5A5}};
`ifdef AES_ENTROPY_RESP_REP_CHECK_EN
    model_on = 1'b0;
    step(1, 1, 0, w0);
    step(1, 0, 0, '0);
    step(1, 0, 0, '0);
    check("rep_first_ack", SW'(obs_ack), SW'(1));
    check("rep_first_data", SW'(obs_data), SW'(32'hA5A5A5A5));
    step(1, 0, 0, '0);
    check("rep_second_blocked", SW'(obs_ack), SW'(0));
    check("rep_err_not_yet", SW'(obs_err), SW'(0));
    repeat (3) begin
      step(1, 0, 0, '0);
      check("rep_err_sticky", SW'(obs_err), SW'(1));
      check("rep_err_no_ack", SW'(obs_ack), SW'(0));
      check("rep_err_ready", SW'(obs_ready), SW'(0));
    end
    step(0, 0, 1, '0);
    step(0, 0, 0, '0);
    check("rep_err_cleared", SW'(obs_err), SW'(0));
    model_clear();
    model_on = 1'b1;
`else
    step(1, 1, 0, w0);
    step(1, 0, 0, '0);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, '0);
      check("norep_ack", SW'(obs_ack), SW'(1));
      check("norep_data", SW'(obs_data), SW'(32'hA5A5A5A5));
      check("norep_err", SW'(obs_err), SW'(0));
    end
    step(1, 0, 0, '0);
    check("norep_done", SW'(obs_ack), SW'(0));
`endif

    // Reset in the middle of a word.
    w0 = rnd_word();
    step(1, 1, 0, w0);
    step(1, 0, 0, '0);
    step(1, 0, 0, '0);
    check("prerst_ack", SW'(obs_ack), SW'(1));
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    check("midrst_ack", SW'(entropy_ack_o), SW'(0));
    check("midrst_data", SW'(entropy_o), SW'(0));
    check("midrst_rep_err", SW'(rep_err_o), SW'(0));
    @(negedge clk_i);
    rst_ni = 1'b1;
    model_clear();
    w1 = rnd_word();
    step(1, 1, 0, w1);
    step(1, 0, 0, '0);
    check("postrst_no_old", SW'(obs_ack), SW'(0));
    step(1, 0, 0, '0);
    check("postrst_ack", SW'(obs_ack), SW'(1));
    check("postrst_data", SW'(obs_data), SW'(chunk(w1, 0)));
    repeat (4) step(1, 0, 0, '0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 7), $urandom_range(0, 1) == 1, ($urandom_range(0, 49) == 0), rnd_word());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
